// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared state encoding, frame timing and control-code constants for the tx scheduler
package mtm_alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_t;

   localparam int TIMER_W    = 16;
   localparam int FRAME_DATA = 56;
   localparam int FRAME_ERR  = 12;

   localparam logic [7:0] CTL_IDLE = 8'hFF;
   localparam logic [7:0] ERR_DATA = 8'hC9;
   localparam logic [7:0] ERR_CRC  = 8'hA5;
   localparam logic [7:0] ERR_OP   = 8'h93;

   function automatic logic [TIMER_W-1:0] frame_len(input logic is_err);
      return is_err ? TIMER_W'(FRAME_ERR) : TIMER_W'(FRAME_DATA);
   endfunction

endpackage

// File: rtl/mtm_alu_tx_scheduler_if.sv
// rtl/mtm_alu_tx_scheduler_if.sv - result/error offer and serializer bus; drop_cnt only with MTM_ALU_TXSCHED_STATS_EN
interface mtm_alu_tx_scheduler_if;

   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_C;
   logic [7:0]  res_CTL;
   logic        err_valid;
   logic [7:0]  err_CTL;
   logic [31:0] ser_C;
   logic [7:0]  ser_CTL;
   logic        ser_load;
   logic        busy;

`ifdef MTM_ALU_TXSCHED_STATS_EN
   logic [7:0]  drop_cnt;

   modport master (
      output res_valid, res_C, res_CTL, err_valid, err_CTL,
      input  res_ready, ser_C, ser_CTL, ser_load, busy, drop_cnt
   );

   modport slave (
      input  res_valid, res_C, res_CTL, err_valid, err_CTL,
      output res_ready, ser_C, ser_CTL, ser_load, busy, drop_cnt
   );
`else
   modport master (
      output res_valid, res_C, res_CTL, err_valid, err_CTL,
      input  res_ready, ser_C, ser_CTL, ser_load, busy
   );

   modport slave (
      input  res_valid, res_C, res_CTL, err_valid, err_CTL,
      output res_ready, ser_C, ser_CTL, ser_load, busy
   );
`endif

endinterface

// File: rtl/mtm_alu_txsched_fifo.sv
// rtl/mtm_alu_txsched_fifo.sv - synchronous power-of-two result queue with registered pointers
module mtm_alu_txsched_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 40
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mtm_alu_tx_scheduler.sv
// rtl/mtm_alu_tx_scheduler.sv - frame scheduler for results and errors; MTM_ALU_TXSCHED_STATS_EN adds drop_cnt
module mtm_alu_tx_scheduler
   import mtm_alu_pkg::*;
#(
   parameter int RES_FIFO_DEPTH = 2,
   parameter int GAP_CYCLES     = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   mtm_alu_tx_scheduler_if.slave  bus
);

   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

   tx_state_t          state;
   logic [TIMER_W-1:0] timer;
   logic               sel_err;
   logic               last_err;
   logic               err_full;
   logic [7:0]         err_code;
   logic               q_full;
   logic               q_empty;
   logic [39:0]        q_head;
   logic               ready;
   logic               pending;
   logic               pick_err;
   logic               ser_load_q;
   logic [31:0]        ser_c_q;
   logic [7:0]         ser_ctl_q;

   assign ready   = !reset && !q_full;
   assign pending = err_full || !q_empty;
   // Errors normally win, but a queued result gets the slot right after an error frame.
   assign pick_err = err_full && !(last_err && !q_empty);

   mtm_alu_txsched_fifo #(
      .DEPTH (RES_FIFO_DEPTH),
      .WIDTH (40)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.res_valid && ready),
      .pop   (state == ST_LOAD && !sel_err),
      .wdata ({bus.res_C, bus.res_CTL}),
      .rdata (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         err_full <= 1'b0;
         err_code <= 8'h00;
      end else if (bus.err_valid && !err_full) begin
         err_full <= 1'b1;
         err_code <= bus.err_CTL;
      end else if (state == ST_LOAD && sel_err) begin
         err_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= '0;
         sel_err    <= 1'b0;
         last_err   <= 1'b0;
         ser_load_q <= 1'b0;
         ser_c_q    <= '0;
         ser_ctl_q  <= CTL_IDLE;
      end else begin
         ser_load_q <= 1'b0;
         ser_c_q    <= '0;
         ser_ctl_q  <= CTL_IDLE;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  state      <= ST_LOAD;
                  sel_err    <= pick_err;
                  last_err   <= pick_err;
                  ser_load_q <= 1'b1;
                  ser_c_q    <= pick_err ? 32'd0 : q_head[39:8];
                  ser_ctl_q  <= pick_err ? err_code : q_head[7:0];
               end
            end
            ST_LOAD: begin
               state <= ST_SEND;
               timer <= frame_len(sel_err);
            end
            ST_SEND: begin
               timer <= timer - TIMER_ONE;
               if (timer == TIMER_ONE) begin
                  state <= ST_GAP;
                  timer <= TIMER_W'(GAP_CYCLES);
               end
            end
            ST_GAP: begin
               timer <= timer - TIMER_ONE;
               if (timer == TIMER_ONE) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MTM_ALU_TXSCHED_STATS_EN
   logic [7:0] drop_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= 8'd0;
      end else if (bus.err_valid && err_full && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign bus.drop_cnt = drop_cnt;
`endif

   // Outputs are forced to their idle values for the whole reset cycle.
   assign bus.res_ready = ready;
   assign bus.busy      = !reset && (state != ST_IDLE || pending);
   assign bus.ser_load  = !reset && ser_load_q;
   assign bus.ser_C     = reset ? 32'd0 : ser_c_q;
   assign bus.ser_CTL   = reset ? CTL_IDLE : ser_ctl_q;

endmodule

// File: tb/tb_mtm_alu_tx_scheduler.sv
// tb/tb_mtm_alu_tx_scheduler.sv - directed and random checks of the tx scheduler against a frame-timing model
module tb_mtm_alu_tx_scheduler;

   localparam int DEPTH = 2;
   localparam int GAP   = 1;

   typedef struct packed {
      logic [31:0] c;
      logic [7:0]  ctl;
   } item_t;

   typedef struct {
      int          cyc;
      logic [31:0] c;
      logic [7:0]  ctl;
   } frame_t;

   logic clk = 1'b0;
   logic reset;

   mtm_alu_tx_scheduler_if bus ();

   mtm_alu_tx_scheduler #(
      .RES_FIFO_DEPTH (DEPTH),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc = 0;

   // Model: queued results, error slot, and the earliest cycle a new frame may be chosen.
   item_t mq[$];
   bit    m_slot = 0;
   logic [7:0] m_code = 8'h00;
   bit    m_last_err = 0;
   int    m_next = 0;
   int    m_drops = 0;
   bit    m_load = 0;
   item_t m_out = '0;
   int    m_rm_cyc = -1;
   bit    m_rm_err = 0;

   frame_t seen[$];
   bit obs_load, obs_ready, obs_busy, accepted;
   logic [7:0] obs_ctl;
   item_t no_item = '0;
   logic [7:0] codes [3] = '{8'h93, 8'hC9, 8'hA5};
   logic [7:0] exp_order [5] = '{8'h10, 8'hA5, 8'h11, 8'hC9, 8'h12};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      assert (obs === req) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, req, cyc);
      end
   endtask

   function automatic bit m_busy();
      return (cyc < m_next) || (mq.size() > 0) || m_slot;
   endfunction

   task automatic model(input bit rst, input bit rv, input item_t ri, input bit ev, input logic [7:0] ectl);
      bit    ready_c;
      bit    slot_c;
      bit    take_err;
      bit    nxt_load;
      item_t nxt_out;
      if (rst) begin
         mq.delete();
         m_slot = 0; m_last_err = 0; m_next = 0; m_drops = 0;
         m_load = 0; m_rm_cyc = -1;
         return;
      end
      ready_c  = mq.size() < DEPTH;
      slot_c   = m_slot;
      nxt_load = 0;
      nxt_out  = '0;
      if (cyc >= m_next && (slot_c || mq.size() > 0)) begin
         take_err   = slot_c && !(m_last_err && mq.size() > 0);
         nxt_load   = 1;
         nxt_out    = take_err ? item_t'({32'd0, m_code}) : mq[0];
         m_last_err = take_err;
         m_rm_cyc   = cyc + 1;
         m_rm_err   = take_err;
         m_next     = cyc + 1 + (take_err ? 12 : 56) + GAP + 1;
      end
      if (cyc == m_rm_cyc) begin
         if (m_rm_err) m_slot = 0;
         else void'(mq.pop_front());
      end
      if (rv && ready_c) mq.push_back(ri);
      if (ev) begin
         if (slot_c) begin
            if (m_drops < 255) m_drops++;
         end else begin
            m_slot = 1;
            m_code = ectl;
         end
      end
      m_load = nxt_load;
      m_out  = nxt_out;
   endtask

   task automatic step(input bit rst, input bit rv, input item_t ri, input bit ev, input logic [7:0] ectl);
      reset = rst;
      bus.res_valid = rv; bus.res_C = ri.c; bus.res_CTL = ri.ctl;
      bus.err_valid = ev; bus.err_CTL = ectl;
      #1;
      obs_load  = bus.ser_load;
      obs_ready = bus.res_ready;
      obs_busy  = bus.busy;
      obs_ctl   = bus.ser_CTL;
      chk("ser_load", 32'(bus.ser_load), 32'(!rst && m_load));
      chk("ser_C", bus.ser_C, (rst || !m_load) ? 32'd0 : m_out.c);
      chk("ser_CTL", 32'(bus.ser_CTL), (rst || !m_load) ? 32'hFF : 32'(m_out.ctl));
      chk("res_ready", 32'(bus.res_ready), 32'(!rst && mq.size() < DEPTH));
      chk("busy", 32'(bus.busy), 32'(!rst && m_busy()));
`ifdef MTM_ALU_TXSCHED_STATS_EN
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
`endif
      if (bus.ser_load) seen.push_back('{cyc, bus.ser_C, bus.ser_CTL});
      accepted = rv && !rst && (mq.size() < DEPTH);
      @(posedge clk);
      model(rst, rv, ri, ev, ectl);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, no_item, 0, 8'h00);
   endtask

   task automatic push(input item_t it);
      for (int i = 0; i < 200; i++) begin
         step(0, 1, it, 0, 8'h00);
         if (accepted) break;
      end
      chk("push_accepted", 32'(accepted), 32'd1);
   endtask

   task automatic err(input logic [7:0] code);
      step(0, 0, no_item, 1, code);
   endtask

   task automatic drain();
      for (int i = 0; i < 1000 && m_busy(); i++) idle(1);
      idle(1);
      chk("drain_busy", 32'(obs_busy), 32'd0);
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 300 && seen.size() < n; i++) idle(1);
      chk("wait_frames", 32'(seen.size()), 32'(n));
   endtask

   initial begin
      int t0;
      int l0;
      for (int i = 0; i < 3; i++) step(1, 1, item_t'({32'h1, 8'h1}), 1, 8'h93);
      idle(1);
      chk("ready_after_reset", 32'(obs_ready), 32'd1);

      // Single result latency and data-frame spacing.
      seen.delete();
      t0 = cyc;
      push(item_t'({32'hDEADBEEF, 8'h0A}));
      push(item_t'({32'hCAFEF00D, 8'h0B}));
      drain();
      chk("frames_two", 32'(seen.size()), 32'd2);
      chk("latency", 32'(seen[0].cyc - t0), 32'd2);
      chk("first_C", seen[0].c, 32'hDEADBEEF);
      chk("first_CTL", 32'(seen[0].ctl), 32'h0A);
      chk("data_spacing_min", 32'((seen[1].cyc - seen[0].cyc) >= 56 + GAP), 32'd1);

      // Simultaneous error and result: error first, then result after a 12-cycle frame.
      seen.delete();
      step(0, 1, item_t'({32'h00000001, 8'h05}), 1, 8'h93);
      drain();
      chk("err_first_CTL", 32'(seen[0].ctl), 32'h93);
      chk("err_first_C", seen[0].c, 32'd0);
      chk("res_second_C", seen[1].c, 32'd1);
      chk("err_spacing", 32'(seen[1].cyc - seen[0].cyc), 32'(1 + 12 + GAP + 1));

      // Three errors while a data frame is in SEND: only the first survives.
      seen.delete();
      push(item_t'({32'h12345678, 8'h01}));
      idle(5);
      err(8'hC9); err(8'hA5); err(8'h93);
      drain();
      chk("drop_frames", 32'(seen.size()), 32'd2);
      chk("kept_err", 32'(seen[1].ctl), 32'hC9);
`ifdef MTM_ALU_TXSCHED_STATS_EN
      chk("drop_total", 32'(bus.drop_cnt), 32'd2);
`endif

      // Back-to-back pushes into a depth-2 queue.
      seen.delete();
      push(item_t'({32'hA0, 8'h21}));
      push(item_t'({32'hA1, 8'h22}));
      step(0, 1, item_t'({32'hA2, 8'h23}), 0, 8'h00);
      chk("ready_full", 32'(obs_ready), 32'd0);
      if (!accepted) push(item_t'({32'hA2, 8'h23}));
      drain();
      chk("fifo_frames", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3; i++) chk("fifo_order", seen[i].c, 32'hA0 + 32'(i));

      // Alternation: error, result, then a late error beats the remaining result.
      seen.delete();
      push(item_t'({32'hB0, 8'h10}));
      idle(3);
      push(item_t'({32'hB1, 8'h11}));
      push(item_t'({32'hB2, 8'h12}));
      err(8'hA5);
      wait_frames(3);
      idle(2);
      err(8'hC9);
      drain();
      chk("alt_frames", 32'(seen.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("alt_order", 32'(seen[i].ctl), 32'(exp_order[i]));

      // Reset in the middle of SEND abandons the frame and flushes the queue.
      seen.delete();
      push(item_t'({32'hC0, 8'h31}));
      push(item_t'({32'hC1, 8'h32}));
      wait_frames(1);
      l0 = seen[0].cyc;
      while (cyc < l0 + 27) idle(1);
      step(1, 0, no_item, 0, 8'h00);
      idle(1);
      chk("rst_busy", 32'(obs_busy), 32'd0);
      chk("rst_ctl", 32'(obs_ctl), 32'hFF);
      chk("rst_ready", 32'(obs_ready), 32'd1);
      idle(80);
      chk("rst_no_load", 32'(seen.size()), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         item_t it;
         it.c   = $urandom;
         it.ctl = 8'($urandom_range(0, 127));
         step($urandom_range(0, 999) == 0, $urandom_range(0, 2) == 0, it,
              $urandom_range(0, 29) == 0, codes[$urandom_range(0, 2)]);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mtm_alu_tx_scheduler.md
MTM_ALU_TX_SCHEDULER -- requirements
Module: mtm_alu_tx_scheduler

Interface
REQ-001 Parameter RES_FIFO_DEPTH, default 2, SHALL set the result queue depth (power of two, ≥2).
REQ-002 Parameter GAP_CYCLES, default 1, SHALL set the idle cycles between frames (≥1).
REQ-003 clk  in  1  single clock, posedge active.
REQ-004 reset  in  1  synchronous, active-HIGH reset.
REQ-005 res_valid  in  1  result offer from core.
REQ-006 res_ready  out  1  result queue can accept.
REQ-007 res_C  in  32  result data.
REQ-008 res_CTL  in  8  result control byte (bit7=0).
REQ-009 err_valid  in  1  one-cycle error report.
REQ-010 err_CTL  in  8  error code: 0x93, 0xC9 or 0xA5.
REQ-011 ser_C  out  32  data presented to serializer.
REQ-012 ser_CTL  out  8  control presented to serializer.
REQ-013 ser_load  out  1  one-cycle frame-start strobe.
REQ-014 busy  out  1  high in any state other than IDLE, or while the queue or the error slot is non-empty.

Function
REQ-015 Results SHALL be pushed when res_valid&&res_ready; res_ready SHALL equal queue-not-full, and a pop in the same cycle SHALL NOT raise res_ready on a full queue.
REQ-016 Errors SHALL be held in a 1-entry slot; err_valid while the slot is full SHALL drop the new error and keep the old one.
REQ-017 FSM states SHALL be IDLE, LOAD, SEND and GAP.
REQ-018 IDLE→LOAD SHALL occur on the cycle after any pending item exists.
REQ-019 LOAD SHALL last exactly 1 cycle: ser_load=1, ser_C/ser_CTL = selected item, item popped.
REQ-020 LOAD→SEND SHALL load the timer with FRAME_DATA=56 for a result or FRAME_ERR=12 for an error; ser_C SHALL be 0 for an error.
REQ-021 SEND SHALL decrement the timer every cycle and go to GAP when the timer reaches 0.
REQ-022 GAP SHALL last GAP_CYCLES cycles, then go to IDLE.
REQ-023 Outside LOAD, ser_CTL SHALL be 0xFF (serializer idle code), ser_C SHALL be 0 and ser_load SHALL be 0.
REQ-024 Arbitration: a pending error SHALL win over a pending result, except immediately after an error frame when a result is pending; the result then wins (anti-starvation alternation).
REQ-025 Results SHALL be sent in push order; no result SHALL be dropped.
REQ-026 A new item arriving during SEND or GAP SHALL NOT pre-empt the frame in progress.
REQ-027 Minimum latency: push at cycle t → ser_load at t+2 when idle and empty.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, flush the queue, clear the error slot and clear the timer.
REQ-029 During reset, outputs SHALL be res_ready=0, ser_load=0, ser_C=0, ser_CTL=0xFF and busy=0; res_ready SHALL rise on the first cycle after reset.
REQ-030 Reset mid-SEND SHALL abandon the frame with no further ser_load.

Configuration
REQ-031 With MTM_ALU_TXSCHED_STATS_EN defined, the block SHALL add output drop_cnt (8 bits): it counts dropped errors, saturates at 255 and clears on reset.
REQ-032 Without MTM_ALU_TXSCHED_STATS_EN, the drop_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package mtm_alu_pkg SHALL hold the state encoding, FRAME_DATA, FRAME_ERR, the CTL_IDLE=0xFF constant and the three error-code constants.
REQ-034 The result queue SHALL be a sub-module, mtm_alu_txsched_fifo (synchronous, registered pointers, full/empty flags).

Verification
REQ-035 Single result C=0xDEADBEEF, CTL=0x0A on an idle block → ser_load at t+2 with ser_C=0xDEADBEEF and ser_CTL=0x0A; next ser_load no earlier than 56+GAP_CYCLES cycles later.
REQ-036 Error 0x93 and result 0x00000001 arriving in the same cycle → error frame first (12 cycles), then the result.
REQ-037 Errors 0xC9, 0xA5 and 0x93 on consecutive cycles while SEND is busy → 0xC9 sent; the other two dropped; drop_cnt=2 with the macro defined.
REQ-038 Three results pushed back-to-back with depth 2 → res_ready low after the second push (or third if a pop intervened); all accepted results emerge in order.
REQ-039 Error pending plus two results pending → order is error, result, then any new error before the second result.
REQ-040 Reset asserted at SEND timer=30 → the next cycle shows IDLE, ser_CTL=0xFF, busy=0, and the queue is empty.
